// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - memory read and decoder handshake bundle for fetch_unit
// Ports (signals):
//   mem_req/mem_addr       fetch -> memory read request and address
//   mem_rdata/mem_ack      memory -> fetch read data and same-cycle completion
//   instr/instr_valid      fetch -> decoder byte and valid flag
//   instr_ready            decoder -> fetch consume strobe
//   pc                     fetch -> decoder address of next byte to fetch
//   ld_pc/ld_pc_val        decoder -> fetch redirect request and target
// Modports: master = fetch unit side, slave = memory/decoder side.
interface fetch_unit_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [7:0]  instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] pc;
    logic        ld_pc;
    logic [15:0] ld_pc_val;

    modport master (
        output mem_req, mem_addr, instr, instr_valid, pc,
        input  mem_rdata, mem_ack, instr_ready, ld_pc, ld_pc_val
    );

    modport slave (
        input  mem_req, mem_addr, instr, instr_valid, pc,
        output mem_rdata, mem_ack, instr_ready, ld_pc, ld_pc_val
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - byte-wide instruction fetch with reset-vector load and redirect
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fetch_unit_if.master: memory read port, decoder byte handshake, pc, redirect
// Parameter:
//   RESET_VEC  address of the reset-vector low byte; high byte lives at RESET_VEC+1
module fetch_unit #(
    parameter logic [15:0] RESET_VEC = 16'hFFFC
) (
    input  logic        clk,
    input  logic        rst_n,
    fetch_unit_if.master bus
);

    localparam logic [15:0] VEC_HI_ADDR = RESET_VEC + 16'd1;

    typedef enum logic [1:0] {
        VEC_LO,
        VEC_HI,
        FETCH,
        HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [7:0]  instr_q, instr_d;
    logic        instr_valid_q, instr_valid_d;
    logic [7:0]  vec_lo_q, vec_lo_d;
    logic        mem_req_c;
    logic [15:0] mem_addr_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= VEC_LO;
            pc_q          <= 16'h0000;
            instr_q       <= 8'h00;
            instr_valid_q <= 1'b0;
            vec_lo_q      <= 8'h00;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            vec_lo_q      <= vec_lo_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        vec_lo_d      = vec_lo_q;
        mem_req_c     = 1'b0;
        mem_addr_c    = pc_q;

        unique case (state_q)
            VEC_LO: begin
                // Redirects are meaningless until the vector has been loaded.
                mem_req_c  = 1'b1;
                mem_addr_c = RESET_VEC;
                if (bus.mem_ack) begin
                    vec_lo_d = bus.mem_rdata;
                    state_d  = VEC_HI;
                end
            end
            VEC_HI: begin
                mem_req_c  = 1'b1;
                mem_addr_c = VEC_HI_ADDR;
                if (bus.mem_ack) begin
                    pc_d    = {bus.mem_rdata, vec_lo_q};
                    state_d = FETCH;
                end
            end
            FETCH: begin
                mem_req_c  = 1'b1;
                mem_addr_c = pc_q;
                // Redirect wins: any data acked this cycle belongs to the old stream.
                if (bus.ld_pc) begin
                    pc_d          = bus.ld_pc_val;
                    instr_valid_d = 1'b0;
                    state_d       = FETCH;
                end else if (bus.mem_ack) begin
                    instr_d       = bus.mem_rdata;
                    instr_valid_d = 1'b1;
                    pc_d          = pc_q + 16'd1;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                // No request while a byte is parked; a stray ack is ignored.
                if (bus.ld_pc) begin
                    pc_d          = bus.ld_pc_val;
                    instr_valid_d = 1'b0;
                    state_d       = FETCH;
                end else if (bus.instr_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = FETCH;
                end
            end
            default: begin
                state_d = VEC_LO;
            end
        endcase
    end

    assign bus.mem_req     = mem_req_c;
    assign bus.mem_addr    = mem_addr_c;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.pc          = pc_q;

endmodule
